// File: rtl/char_plotter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : char_plotter_pkg
//  Description : Shared constants, FSM state type and glyph decoders for the
//                character plotter.
//  Revision    : 1.0 - initial release
// ============================================================================
package char_plotter_pkg;

    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 10;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Character codes (A=1 ordering); anything else renders as an empty cell
    localparam logic [5:0] CHAR_I = 6'd9;
    localparam logic [5:0] CHAR_L = 6'd12;

    localparam logic [5:0] COLOUR_I = 6'h3F;
    localparam logic [5:0] COLOUR_L = 6'h30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // 'I': serifed bar, three cells wide on the top and bottom rows, stem at dx=4
    function automatic logic glyph_i(input logic [7:0] dx, input logic [7:0] dy);
        logic r;
        if (dy == 8'd0 || dy == 8'd9)
            r = (dx >= 8'd3) && (dx <= 8'd5);
        else
            r = (dx == 8'd4);
        return r;
    endfunction

    // 'L': stem at dx=1, foot along the bottom row out to dx=6
    function automatic logic glyph_l(input logic [7:0] dx, input logic [7:0] dy);
        logic r;
        r = (dx == 8'd1) || ((dy == 8'd9) && (dx >= 8'd1) && (dx <= 8'd6));
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_glyph_rom.sv
`default_nettype none
// ============================================================================
//  Module      : char_glyph_rom
//  Description : Combinational glyph lookup; maps (char_code, dx, dy) to a
//                pixel enable and the character's colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module char_glyph_rom
    import char_plotter_pkg::*;
#(
    parameter int DX_W = 3,
    parameter int DY_W = 4
) (
    input  logic [5:0]      char_code,
    input  logic [DX_W-1:0] dx,
    input  logic [DY_W-1:0] dy,
    output logic            enable,
    output logic [5:0]      colour
);

    logic [7:0] dx8;
    logic [7:0] dy8;

    // Dispatch to the per-character decoder; unknown codes stay blank
    always_comb begin
        dx8    = 8'(dx);
        dy8    = 8'(dy);
        enable = 1'b0;
        colour = 6'h00;
        case (char_code)
            CHAR_I: begin
                enable = glyph_i(dx8, dy8);
                colour = COLOUR_I;
            end
            CHAR_L: begin
                enable = glyph_l(dx8, dy8);
                colour = COLOUR_L;
            end
            default: begin
                enable = 1'b0;
                colour = 6'h00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/char_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : char_plotter
//  Description : Scans one glyph cell-by-cell and streams clipped pixel writes
//                to a framebuffer writer with valid/ready handshaking.
//                Latency without backpressure: the done pulse is seen
//                GLYPH_W*GLYPH_H+2 clock edges after the accepting edge
//                (one edge per cell, one to drain the last output, one to
//                leave FINISH).
//  Revision    : 1.0 - initial release
// ============================================================================
module char_plotter
    import char_plotter_pkg::*;
#(
    parameter int GLYPH_W  = char_plotter_pkg::GLYPH_W,
    parameter int GLYPH_H  = char_plotter_pkg::GLYPH_H,
    parameter int SCREEN_W = char_plotter_pkg::SCREEN_W,
    parameter int SCREEN_H = char_plotter_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [5:0] char_code,
    input  logic [7:0] org_x,
    input  logic [7:0] org_y,
    input  logic       erase,
    input  logic [5:0] bg_colour,
    output logic       plot,
    input  logic       plot_ready,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [5:0] vga_colour,
    output logic       busy,
    output logic       done
);

    localparam int DX_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int DY_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam logic [DX_W-1:0] DX_LAST = DX_W'(GLYPH_W - 1);
    localparam logic [DY_W-1:0] DY_LAST = DY_W'(GLYPH_H - 1);

    state_t          state, state_nx;
    logic [5:0]      char_q;
    logic [7:0]      ox_q, oy_q;
    logic            erase_q;
    logic [5:0]      bg_q;
    logic [DX_W-1:0] dx;
    logic [DY_W-1:0] dy;
    logic            scan_end;     // every cell visited; only the last output may remain

    logic            glyph_en;
    logic [5:0]      glyph_col;
    logic [8:0]      sum_x, sum_y; // 9 bits so positions past 255 clip instead of wrapping
    logic            emit, xfer_ok, last_cell;
    logic            accept, visit, drain;

    char_glyph_rom #(
        .DX_W (DX_W),
        .DY_W (DY_W)
    ) u_rom (
        .char_code (char_q),
        .dx        (dx),
        .dy        (dy),
        .enable    (glyph_en),
        .colour    (glyph_col)
    );

    // Screen position of the current cell and whether it produces a write
    always_comb begin
        sum_x     = {1'b0, ox_q} + 9'(dx);
        sum_y     = {1'b0, oy_q} + 9'(dy);
        emit      = (glyph_en || erase_q) &&
                    (sum_x < 9'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));
        xfer_ok   = !plot || plot_ready;
        last_cell = (dx == DX_LAST) && (dy == DY_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state and datapath controls; SCAN and HOLD share the advance rule
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        visit    = 1'b0;
        drain    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN, HOLD: begin
                if (!xfer_ok) begin
                    state_nx = HOLD;
                end else if (scan_end) begin
                    drain    = 1'b1;
                    state_nx = FINISH;
                end else begin
                    visit    = 1'b1;
                    state_nx = SCAN;
                end
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Input latches, cell counters and registered pixel outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            char_q     <= 6'h00;
            ox_q       <= 8'h00;
            oy_q       <= 8'h00;
            erase_q    <= 1'b0;
            bg_q       <= 6'h00;
            dx         <= '0;
            dy         <= '0;
            scan_end   <= 1'b0;
            plot       <= 1'b0;
            vga_x      <= 8'h00;
            vga_y      <= 8'h00;
            vga_colour <= 6'h00;
            done       <= 1'b0;
        end else begin
            done <= (state == FINISH);
            if (accept) begin
                char_q   <= char_code;
                ox_q     <= org_x;
                oy_q     <= org_y;
                erase_q  <= erase;
                bg_q     <= bg_colour;
                dx       <= '0;
                dy       <= '0;
                scan_end <= 1'b0;
            end
            if (visit) begin
                plot <= emit;
                if (emit) begin
                    vga_x      <= sum_x[7:0];
                    vga_y      <= sum_y[7:0];
                    vga_colour <= erase_q ? bg_q : glyph_col;
                end
                if (last_cell) begin
                    scan_end <= 1'b1;
                end else if (dx == DX_LAST) begin
                    dx <= '0;
                    dy <= dy + DY_W'(1);
                end else begin
                    dx <= dx + DX_W'(1);
                end
            end
            if (drain) plot <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_char_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_char_plotter
//  Description : Scoreboard bench for char_plotter; stimulus pushes expected
//                pixel writes, a monitor pops them on every transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_char_plotter;

    logic       clk = 1'b0;
    logic       resetn, start, erase, plot_ready;
    logic [5:0] char_code, bg_colour, vga_colour;
    logic [7:0] org_x, org_y, vga_x, vga_y;
    logic       plot, busy, done;

    int          checks = 0;
    int          errors = 0;
    int          writes = 0;
    logic [21:0] exp_q[$];
    bit          stall_armed = 1'b0;
    int          stall_cnt = 0;

    char_plotter dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .char_code  (char_code),
        .org_x      (org_x),
        .org_y      (org_y),
        .erase      (erase),
        .bg_colour  (bg_colour),
        .plot       (plot),
        .plot_ready (plot_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic push_w(input int x, input int y, input logic [5:0] c);
        if (x < 160 && y < 120) exp_q.push_back({8'(x), 8'(y), c});
    endtask

    // 'I' cells in scan order, relative to the origin
    task automatic push_i(input int ox, input int oy);
        int xs[14];
        int ys[14];
        xs = '{3, 4, 5, 4, 4, 4, 4, 4, 4, 4, 4, 3, 4, 5};
        ys = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9};
        for (int i = 0; i < 14; i++) push_w(ox + xs[i], oy + ys[i], 6'h3F);
    endtask

    // 'L' cells in scan order, relative to the origin
    task automatic push_l(input int ox, input int oy);
        int xs[15];
        int ys[15];
        xs = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 3, 4, 5, 6};
        ys = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9, 9, 9};
        for (int i = 0; i < 15; i++) push_w(ox + xs[i], oy + ys[i], 6'h30);
    endtask

    task automatic push_erase(input int ox, input int oy, input logic [5:0] c);
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 8; x++) push_w(ox + x, oy + y, c);
    endtask

    // Monitor: optional first-write stall, then scoreboard pop on each transfer
    always @(negedge clk) begin
        if (resetn) begin
            if (stall_armed && plot) begin
                if (stall_cnt < 5) begin
                    check(vga_x == 8'd13 && vga_y == 8'd20 && vga_colour == 6'h3F, "hold_stable",
                          $sformatf("got (%0d,%0d,%h) want (13,20,3f)", vga_x, vga_y, vga_colour));
                    stall_cnt++;
                end else begin
                    plot_ready  = 1'b1;
                    stall_armed = 1'b0;
                end
            end
            if (plot && plot_ready) begin
                writes++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_write",
                          $sformatf("got (%0d,%0d,%h) want none", vga_x, vga_y, vga_colour));
                end else begin
                    logic [21:0] e;
                    e = exp_q.pop_front();
                    check({vga_x, vga_y, vga_colour} == e, "write_data",
                          $sformatf("got (%0d,%0d,%h) want (%0d,%0d,%h)", vga_x, vga_y, vga_colour,
                                    e[21:14], e[13:6], e[5:0]));
                end
            end
        end
    end

    task automatic set_inputs(input logic [5:0] code, input logic [7:0] ox, input logic [7:0] oy,
                              input logic er, input logic [5:0] bg);
        char_code = code;
        org_x     = ox;
        org_y     = oy;
        erase     = er;
        bg_colour = bg;
    endtask

    // Draw one character; expectations must already be queued
    task automatic draw(input logic [5:0] code, input logic [7:0] ox, input logic [7:0] oy,
                        input logic er, input logic [5:0] bg, input int exp_writes,
                        input int exp_lat, input int poke_at, input bit stall);
        int cyc;
        bit got;
        writes = 0;
        @(posedge clk); #1;
        if (stall) begin
            stall_cnt   = 0;
            stall_armed = 1'b1;
            plot_ready  = 1'b0;
        end
        set_inputs(code, ox, oy, er, bg);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check(busy == 1'b1, "busy_after_start", $sformatf("got %0b want 1", busy));
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == poke_at) begin
                start = 1'b1;
                set_inputs(6'd12, 8'd0, 8'd0, 1'b1, 6'h15);
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        check(got && cyc == exp_lat, "latency",
              $sformatf("got %0d cycles (done seen %0b) want %0d", cyc, got, exp_lat));
        check(writes == exp_writes, "write_count", $sformatf("got %0d want %0d", writes, exp_writes));
        check(exp_q.size() == 0, "queue_empty", $sformatf("got %0d left want 0", exp_q.size()));
        check(busy == 1'b0, "idle_at_done", $sformatf("got busy %0b want 0", busy));
        @(posedge clk); #1;
        check(done == 1'b0, "done_one_cycle", $sformatf("got %0b want 0", done));
        exp_q.delete();
    endtask

    initial begin
        int  cyc;
        bit  seen;
        resetn     = 1'b0;
        start      = 1'b0;
        plot_ready = 1'b1;
        set_inputs(6'h00, 8'h00, 8'h00, 1'b0, 6'h00);
        repeat (2) @(posedge clk);
        #1;
        check({plot, busy, done} == 3'b000, "reset_flags",
              $sformatf("got plot/busy/done %b want 000", {plot, busy, done}));
        check({vga_x, vga_y, vga_colour} == 22'h0, "reset_outputs",
              $sformatf("got (%0d,%0d,%h) want (0,0,00)", vga_x, vga_y, vga_colour));
        resetn = 1'b1;

        // 'I' at (10,20), with an ignored start pulse mid-scan
        push_i(10, 20);
        draw(6'd9, 8'd10, 8'd20, 1'b0, 6'h00, 14, 82, 40, 1'b0);

        // Erase at (0,0): full 8x10 block in background colour
        push_erase(0, 0, 6'h05);
        draw(6'd9, 8'd0, 8'd0, 1'b1, 6'h05, 80, 82, 0, 1'b0);

        // Erase at the bottom-right corner: 4 columns x 5 rows visible
        push_erase(156, 115, 6'h2A);
        draw(6'd0, 8'd156, 8'd115, 1'b1, 6'h2A, 20, 82, 0, 1'b0);

        // Right-edge clipping
        push_i(155, 0);
        draw(6'd9, 8'd155, 8'd0, 1'b0, 6'h00, 12, 82, 0, 1'b0);

        // Far right: glyph and erase must clip, not wrap into x=0/1
        draw(6'd9, 8'd250, 8'd0, 1'b0, 6'h00, 0, 82, 0, 1'b0);
        draw(6'd9, 8'd250, 8'd0, 1'b1, 6'h11, 0, 82, 0, 1'b0);

        // Unknown code renders nothing but still completes
        draw(6'h3E, 8'd20, 8'd20, 1'b0, 6'h00, 0, 82, 0, 1'b0);

        // 'L' at (100,100)
        push_l(100, 100);
        draw(6'd12, 8'd100, 8'd100, 1'b0, 6'h00, 15, 82, 0, 1'b0);

        // Backpressure: first write held for 5 cycles
        push_i(10, 20);
        draw(6'd9, 8'd10, 8'd20, 1'b0, 6'h00, 14, 87, 0, 1'b1);
        check(stall_cnt == 5, "stall_cycles", $sformatf("got %0d want 5", stall_cnt));

        // start held from the FINISH cycle: ignored there, accepted one cycle later
        push_i(10, 20);
        push_i(10, 20);
        writes = 0;
        @(posedge clk); #1;
        set_inputs(6'd9, 8'd10, 8'd20, 1'b0, 6'h00);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 81) start = 1'b1;
            if (done) seen = 1'b1;
        end
        check(seen && cyc == 82, "chain_first_done", $sformatf("got %0d want 82", cyc));
        check(busy == 1'b0, "chain_not_in_finish", $sformatf("got busy %0b want 0", busy));
        @(posedge clk); #1;
        start = 1'b0;
        check(busy == 1'b1, "chain_accept", $sformatf("got busy %0b want 1", busy));
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        check(seen && cyc == 82, "chain_second_done", $sformatf("got %0d want 82", cyc));
        check(writes == 28 && exp_q.size() == 0, "chain_writes",
              $sformatf("got %0d writes, %0d queued want 28, 0", writes, exp_q.size()));
        exp_q.delete();

        // Reset on cycle 30 of a scan: 6 writes already transferred, nothing after
        push_w(13, 20, 6'h3F); push_w(14, 20, 6'h3F); push_w(15, 20, 6'h3F);
        push_w(14, 21, 6'h3F); push_w(14, 22, 6'h3F); push_w(14, 23, 6'h3F);
        writes = 0;
        @(posedge clk); #1;
        set_inputs(6'd9, 8'd10, 8'd20, 1'b0, 6'h00);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check({plot, busy, done} == 3'b000 && {vga_x, vga_y, vga_colour} == 22'h0, "reset_mid_scan",
              $sformatf("got plot/busy/done %b xyc (%0d,%0d,%h) want 000 (0,0,00)",
                        {plot, busy, done}, vga_x, vga_y, vga_colour));
        check(writes == 6 && exp_q.size() == 0, "writes_before_reset",
              $sformatf("got %0d writes, %0d queued want 6, 0", writes, exp_q.size()));
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done || plot) seen = 1'b1;
        end
        check(!seen && writes == 6, "no_done_after_reset",
              $sformatf("got activity %0b writes %0d want 0, 6", seen, writes));
        exp_q.delete();

        push_i(10, 20);
        draw(6'd9, 8'd10, 8'd20, 1'b0, 6'h00, 14, 82, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
